multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and JAL steps, with a memory-wait timeout and sticky error flags.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter bit          SUPPORT_OPIMM = 1'b1,
  parameter bit          SUPPORT_JAL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [2:0] immsel,
  output logic       memread,
  output logic       memwrite,
  output logic [1:0] memtoreg,
  output logic       pcsrc,
  output logic [3:0] state,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  EXEC_I = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     cur;
  state_t     nxt;
  state_t     eff;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;
  logic       bad_op;

  assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign timeout = waiting && !mem_ready && (wait_cnt == TIMEOUT_VAL);

  // next-state decode; a ready memory takes priority over the timeout
  always_comb begin
    nxt    = cur;
    bad_op = 1'b0;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : (timeout ? TRAP : FETCH);
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_RTYPE:          nxt = EXEC_R;
          OP_BRANCH:         nxt = BRANCH;
          OP_OPIMM: begin
            if (SUPPORT_OPIMM) nxt = EXEC_I;
            else begin nxt = TRAP; bad_op = 1'b1; end
          end
          OP_JAL: begin
            if (SUPPORT_JAL) nxt = JAL;
            else begin nxt = TRAP; bad_op = 1'b1; end
          end
          default: begin nxt = TRAP; bad_op = 1'b1; end
        endcase
      end
      MEMADR: nxt = (opcode == OP_STORE) ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : (timeout ? TRAP : MEMRD);
      MEMWR:  nxt = mem_ready ? FETCH : (timeout ? TRAP : MEMWR);
      EXEC_R, EXEC_I: nxt = ALUWB;
      MEMWB, ALUWB, BRANCH, JAL: nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  // state, wait counter and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= FETCH;
      wait_cnt  <= 8'd0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur) wait_cnt <= 8'd0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= wait_cnt;
      if (bad_op) illegal <= 1'b1;
      else illegal <= illegal;
      if (timeout) bus_error <= 1'b1;
      else bus_error <= bus_error;
    end
  end

  assign eff   = rst ? FETCH : cur;
  assign state = eff;

  // Moore control decode; only the fetch/branch write enables look at inputs
  always_comb begin
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    alusrca  = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    immsel   = 3'b000;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 2'b00;
    pcsrc    = 1'b0;
    case (eff)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready && !rst;
        pcwrite = mem_ready && !rst;
      end
      DECODE: begin
        alusrca = 2'b10;
        alusrcb = 2'b10;
        immsel  = 3'b010;
      end
      MEMADR: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        immsel  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      MEMRD:  begin memread = 1'b1; iord = 1'b1; end
      MEMWB:  begin regwrite = 1'b1; memtoreg = 2'b01; end
      MEMWR:  begin memwrite = 1'b1; iord = 1'b1; end
      EXEC_R: begin alusrca = 2'b01; aluop = 2'b10; end
      EXEC_I: begin alusrca = 2'b01; alusrcb = 2'b10; aluop = 2'b10; end
      ALUWB:  regwrite = 1'b1;
      BRANCH: begin
        alusrca = 2'b01;
        aluop   = 2'b01;
        pcsrc   = 1'b1;
        pcwrite = zero;
      end
      JAL: begin
        regwrite = 1'b1;
        memtoreg = 2'b10;
        pcsrc    = 1'b1;
        pcwrite  = 1'b1;
      end
      default: pcwrite = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit: instance a (timeout 3, all
// opcodes) walks a vector table; instance b (no OPIMM/JAL) checks illegal decode.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] L = 7'b0000011, S = 7'b0100011, R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011, B = 7'b1100011, J = 7'b1101111;

  logic       rst_a, zero_a, mr_a;
  logic [6:0] op_a;
  logic       pcw_a, irw_a, iord_a, rw_a, mrd_a, mwr_a, pcs_a, ill_a, berr_a;
  logic [1:0] asa_a, asb_a, aop_a, mtr_a;
  logic [2:0] imm_a;
  logic [3:0] st_a;

  logic       rst_b, zero_b, mr_b;
  logic [6:0] op_b;
  logic       pcw_b, irw_b, iord_b, rw_b, mrd_b, mwr_b, pcs_b, ill_b, berr_b;
  logic [1:0] asa_b, asb_b, aop_b, mtr_b;
  logic [2:0] imm_b;
  logic [3:0] st_b;

  multicycle_control_unit #(.MEM_TIMEOUT(3), .SUPPORT_OPIMM(1'b1), .SUPPORT_JAL(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(op_a), .zero(zero_a), .mem_ready(mr_a),
    .pcwrite(pcw_a), .irwrite(irw_a), .iord(iord_a), .regwrite(rw_a),
    .alusrca(asa_a), .alusrcb(asb_a), .aluop(aop_a), .immsel(imm_a),
    .memread(mrd_a), .memwrite(mwr_a), .memtoreg(mtr_a), .pcsrc(pcs_a),
    .state(st_a), .illegal(ill_a), .bus_error(berr_a));

  multicycle_control_unit #(.MEM_TIMEOUT(15), .SUPPORT_OPIMM(1'b0), .SUPPORT_JAL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(op_b), .zero(zero_b), .mem_ready(mr_b),
    .pcwrite(pcw_b), .irwrite(irw_b), .iord(iord_b), .regwrite(rw_b),
    .alusrca(asa_b), .alusrcb(asb_b), .aluop(aop_b), .immsel(imm_b),
    .memread(mrd_b), .memwrite(mwr_b), .memtoreg(mtr_b), .pcsrc(pcs_b),
    .state(st_b), .illegal(ill_b), .bus_error(berr_b));

  logic [17:0] ctl_a;
  assign ctl_a = {pcw_a, irw_a, iord_a, rw_a, asa_a, asb_a, aop_a, imm_a,
                  mrd_a, mwr_a, mtr_a, pcs_a};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [1:0]  flags;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [17:0] ctl(input logic pcw, input logic irw, input logic io,
      input logic rw, input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
      input logic [2:0] imm, input logic mr, input logic mw, input logic [1:0] mtr,
      input logic pcs);
    return {pcw, irw, io, rw, a, b, op, imm, mr, mw, mtr, pcs};
  endfunction

  task automatic add(input logic r, input logic [6:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [17:0] c, input logic [1:0] f);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.mr = mr; v.st = st; v.ctl = c; v.flags = f;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] c_fw, c_fg, c_dec, c_mal, c_mas, c_mrd, c_mwb, c_mwr;
  logic [17:0] c_exr, c_exi, c_awb, c_brt, c_brn, c_jal, c_nil;

  initial begin
    c_fw  = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0);
    c_fg  = ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0);
    c_dec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0);
    c_mal = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0);
    c_mas = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0);
    c_mrd = ctl(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0);
    c_mwb = ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0);
    c_mwr = ctl(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0);
    c_exr = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0);
    c_exi = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0);
    c_awb = ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0);
    c_brt = ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1);
    c_brn = ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1);
    c_jal = ctl(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1);
    c_nil = 18'd0;

    // reset view, then load with ready memory: 0,1,2,3,4
    add(1'b1, L, 1'b0, 1'b1, 4'd0, c_fw, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd2, c_mal, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd4, c_mwb, 2'b00);
    // store, memory ready after two wait cycles
    add(1'b0, S, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, S, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, S, 1'b0, 1'b1, 4'd2, c_mas, 2'b00);
    add(1'b0, S, 1'b0, 1'b0, 4'd5, c_mwr, 2'b00);
    add(1'b0, S, 1'b0, 1'b0, 4'd5, c_mwr, 2'b00);
    add(1'b0, S, 1'b0, 1'b1, 4'd5, c_mwr, 2'b00);
    // R-type, I-type
    add(1'b0, R, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, R, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, R, 1'b0, 1'b1, 4'd6, c_exr, 2'b00);
    add(1'b0, R, 1'b0, 1'b1, 4'd8, c_awb, 2'b00);
    add(1'b0, I, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, I, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, I, 1'b0, 1'b1, 4'd7, c_exi, 2'b00);
    add(1'b0, I, 1'b0, 1'b1, 4'd8, c_awb, 2'b00);
    // branch taken, branch not taken, JAL
    add(1'b0, B, 1'b1, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, B, 1'b1, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, B, 1'b1, 1'b1, 4'd9, c_brt, 2'b00);
    add(1'b0, B, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, B, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, B, 1'b0, 1'b1, 4'd9, c_brn, 2'b00);
    add(1'b0, J, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, J, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, J, 1'b0, 1'b1, 4'd10, c_jal, 2'b00);
    // load: ready arrives exactly when the counter reaches the limit
    add(1'b0, L, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd2, c_mal, 2'b00);
    add(1'b0, L, 1'b0, 1'b0, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b0, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b0, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd4, c_mwb, 2'b00);
    // load that times out
    add(1'b0, L, 1'b0, 1'b1, 4'd0, c_fg, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd1, c_dec, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd2, c_mal, 2'b00);
    for (int k = 0; k < 4; k++) add(1'b0, L, 1'b0, 1'b0, 4'd3, c_mrd, 2'b00);
    add(1'b0, L, 1'b0, 1'b1, 4'd11, c_nil, 2'b01);
    add(1'b0, L, 1'b0, 1'b1, 4'd11, c_nil, 2'b01);
    // reset out of TRAP, then reset in the middle of a fetch wait
    add(1'b1, L, 1'b0, 1'b1, 4'd0, c_fw, 2'b01);
    add(1'b0, L, 1'b0, 1'b0, 4'd0, c_fw, 2'b00);
    add(1'b0, L, 1'b0, 1'b0, 4'd0, c_fw, 2'b00);
    add(1'b1, L, 1'b0, 1'b1, 4'd0, c_fw, 2'b00);
    for (int k = 0; k < 4; k++) add(1'b0, L, 1'b0, 1'b0, 4'd0, c_fw, 2'b00);
    add(1'b0, L, 1'b0, 1'b0, 4'd11, c_nil, 2'b01);

    rst_a = 1'b1; op_a = L; zero_a = 1'b0; mr_a = 1'b0;
    rst_b = 1'b1; op_b = I; zero_b = 1'b0; mr_b = 1'b1;
    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst; op_a = tbl[i].op; zero_a = tbl[i].zero; mr_a = tbl[i].mr;
      #1;
      chk("state", i, 32'(st_a), 32'(tbl[i].st));
      chk("ctrl", i, 32'(ctl_a), 32'(tbl[i].ctl));
      chk("flags", i, 32'({ill_a, berr_a}), 32'(tbl[i].flags));
      tick();
    end

    // undefined opcode on the full-featured instance
    rst_a = 1'b1; mr_a = 1'b1; op_a = 7'b0000000;
    tick();
    rst_a = 1'b0;
    tick();
    chk("a_undef_decode", 0, 32'(st_a), 32'd1);
    tick();
    chk("a_undef_state", 0, 32'(st_a), 32'd11);
    chk("a_undef_illegal", 0, 32'(ill_a), 32'd1);
    chk("a_undef_berr", 0, 32'(berr_a), 32'd0);

    // OPIMM disabled: DECODE -> TRAP, illegal sticky until reset
    rst_b = 1'b0; op_b = I; mr_b = 1'b1;
    #1;
    chk("b_fetch", 0, 32'(st_b), 32'd0);
    tick();
    chk("b_decode", 0, 32'(st_b), 32'd1);
    chk("b_decode_illegal", 0, 32'(ill_b), 32'd0);
    tick();
    chk("b_trap", 0, 32'(st_b), 32'd11);
    chk("b_illegal", 0, 32'(ill_b), 32'd1);
    tick();
    chk("b_trap_hold", 0, 32'(st_b), 32'd11);
    chk("b_illegal_hold", 0, 32'(ill_b), 32'd1);
    chk("b_trap_pcwrite", 0, 32'(pcw_b), 32'd0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; op_b = J;
    #1;
    chk("b_rst_state", 0, 32'(st_b), 32'd0);
    chk("b_rst_illegal", 0, 32'(ill_b), 32'd0);
    // JAL disabled
    tick();
    tick();
    chk("b_jal_trap", 0, 32'(st_b), 32'd11);
    chk("b_jal_illegal", 0, 32'(ill_b), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
